// File: rtl/tlp_tx_pkg.sv
// rtl/tlp_tx_pkg.sv - shared field offsets, word width and arbiter state encodings
package tlp_tx_pkg;

    localparam int TX_SOP_BIT   = 128;
    localparam int TX_EOP_BIT   = 129;
    localparam int TX_EMPTY_BIT = 130;
    localparam int TX_WORD_W    = 131;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RP   = 2'd1,
        ST_USR  = 2'd2
    } arbState_t;

endpackage

// File: rtl/tlp_tx_skid.sv
// rtl/tlp_tx_skid.sv - 2-entry skid/output buffer; entry 0 is always the head
module tlp_tx_skid
    import tlp_tx_pkg::*;
#(
    parameter int W = TX_WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] headData,
    output logic [1:0]   count
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic         doPop;

    assign doPop    = pop && (count != 2'd0);
    assign headData = ent0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, doPop})
                2'b10: begin
                    // a push into a full buffer is dropped; upstream credit rules prevent it
                    if (count == 2'd0) begin
                        ent0 <= pushData;
                    end else if (count == 2'd1) begin
                        ent1 <= pushData;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= pushData;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= pushData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tlp_txrp_arb.sv
// rtl/tlp_txrp_arb.sv - packet-granular arbiter merging root-port FIFO TLPs with the user TX stream
module tlp_txrp_arb
    import tlp_tx_pkg::*;
#(
    parameter int C_DATA_W      = 128,
    parameter bit C_RP_PRIORITY = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RpTLPReady,
    input  logic [C_DATA_W+2:0] TxRpFifoData,
    output logic                TxRpFifoRdReq,
    input  logic [C_DATA_W-1:0] UsrTxData,
    input  logic                UsrTxSop,
    input  logic                UsrTxEop,
    input  logic                UsrTxEmpty,
    input  logic                UsrTxValid,
    output logic                UsrTxReady,
    output logic [C_DATA_W-1:0] TxStData,
    output logic                TxStSop,
    output logic                TxStEop,
    output logic                TxStEmpty,
    output logic                TxStValid,
    input  logic                TxStReady
);

    localparam int WORD_W = C_DATA_W + 3;

    arbState_t         state;
    arbState_t         stateNext;
    logic              lastGrantRp;
    logic              lastGrantRpNext;
    logic              inflight;
    logic [1:0]        skidCnt;
    logic [WORD_W-1:0] skidHead;
    logic [WORD_W-1:0] pushData;
    logic              push;
    logic              pop;
    logic              rpReq;
    logic              usrReq;
    logic              rpEopBack;
    logic              rpRoom;
    logic              rdReq;
    logic              usrReady;

    assign rpReq     = RpTLPReady;
    assign usrReq    = UsrTxValid && UsrTxSop;
    assign pop       = TxStValid && TxStReady;
    assign rpEopBack = inflight && TxRpFifoData[TX_EOP_BIT];

    // a beat leaving this cycle frees the slot the next request will land in
    assign rpRoom = ({1'b0, skidCnt} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;

    assign push     = inflight || (UsrTxValid && usrReady);
    assign pushData = inflight ? TxRpFifoData : {UsrTxEmpty, UsrTxEop, UsrTxSop, UsrTxData};

    always_comb begin
        stateNext       = state;
        lastGrantRpNext = lastGrantRp;
        rdReq           = 1'b0;
        usrReady        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rpReq && (!usrReq || C_RP_PRIORITY || !lastGrantRp)) begin
                    stateNext = ST_RP;
                end else if (usrReq) begin
                    stateNext = ST_USR;
                end
            end
            ST_RP: begin
                // the eop word coming back kills this cycle's request, so nothing is read past eop
                rdReq = rpRoom && !rpEopBack;
                if (rpEopBack) begin
                    stateNext       = ST_IDLE;
                    lastGrantRpNext = 1'b1;
                end
            end
            ST_USR: begin
                usrReady = (skidCnt < 2'd2) || ((skidCnt == 2'd2) && TxStReady);
                if (UsrTxValid && usrReady && UsrTxEop) begin
                    stateNext       = ST_IDLE;
                    lastGrantRpNext = 1'b0;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lastGrantRp <= 1'b0;
            inflight    <= 1'b0;
        end else begin
            state       <= stateNext;
            lastGrantRp <= lastGrantRpNext;
            inflight    <= rdReq;
        end
    end

    tlp_tx_skid #(
        .W (WORD_W)
    ) uSkid (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .headData (skidHead),
        .count    (skidCnt)
    );

    assign TxRpFifoRdReq = rdReq;
    assign UsrTxReady    = usrReady;
    assign TxStValid     = (skidCnt != 2'd0);
    assign TxStData      = skidHead[C_DATA_W-1:0];
    assign TxStSop       = TxStValid && skidHead[TX_SOP_BIT];
    assign TxStEop       = TxStValid && skidHead[TX_EOP_BIT];
    assign TxStEmpty     = TxStValid && skidHead[TX_EMPTY_BIT];

endmodule
